// File: rtl/div_unit_pkg.sv
// Shared constants and types for the iterative MIPS DIV/DIVU unit.
// Holds the FSM state encodings and the decode that drives start_i/signed_i.
package div_unit_pkg;

   localparam int DIV_CYCLES = 32;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU = 6'h1B;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic start;
      logic sgn;
   } div_ctrl_t;

   // Same op/funct decode as the ALU control; feeds start_i / signed_i.
   function automatic div_ctrl_t div_decode(input logic [5:0] op, input logic [5:0] funct);
      div_ctrl_t c;
      c.start = (op == OP_SPECIAL) && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
      c.sgn   = (op == OP_SPECIAL) && (funct == FUNCT_DIV);
      return c;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_i};

   // rem stays below divisor, so a non-negative trial always fits in WIDTH bits.
   always_comb begin
      rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; LO = quotient, HI = remainder.
// Stalls the pipeline while iterating and aborts on flush.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             q_neg_q, r_neg_q;

   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             a_neg, b_neg;
   logic             capture, div_zero, last_step;

   assign a_neg = signed_i & dividend_i[WIDTH-1];
   assign b_neg = signed_i & divisor_i[WIDTH-1];
   // -(2^(WIDTH-1)) maps onto itself, which is the correct unsigned magnitude.
   assign a_mag = a_neg ? -dividend_i : dividend_i;
   assign b_mag = b_neg ? -divisor_i  : divisor_i;

   assign capture   = (state_q == DIV_IDLE) && start_i && !flush_i;
   assign div_zero  = (divisor_i == '0);
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   assign stall_o     = (capture && !div_zero) || ((state_q == DIV_BUSY) && !flush_i);
   assign done_o      = (state_q == DIV_DONE);
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvsr_q),
      .rem_o     (rem_d),
      .quo_o     (quo_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (capture) begin
                  q_neg_q <= a_neg ^ b_neg;
                  r_neg_q <= a_neg;
                  dvsr_q  <= b_mag;
                  rem_q   <= '0;
                  quo_q   <= a_mag;
                  cnt_q   <= '0;
                  if (div_zero) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend_i;
                     state_q     <= DIV_DONE;
                  end else begin
                     state_q     <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (flush_i) begin
                  state_q <= DIV_IDLE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (last_step) begin
                     quotient_q  <= q_neg_q ? -quo_d : quo_d;
                     remainder_q <= r_neg_q ? -rem_d : rem_d;
                     state_q     <= DIV_DONE;
                  end
               end
            end
            // start_i is still the same instruction here, so it is ignored.
            DIV_DONE: state_q <= DIV_IDLE;
            default:  state_q <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Sits directly downstream of the ALU decode: it consumes the same op/funct-decoded control, and its results go to the HI/LO write path (LO = quotient, HI = remainder).
- Holds the pipeline with a stall request while it iterates. Supports pipeline flush (exception) abort.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  EX holds a DIV/DIVU with valid operands (level, not pulse).
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- flush_i  in  1  annul the in-flight divide.
- dividend_i  in  WIDTH  rs value.
- divisor_i  in  WIDTH  rt value.
- stall_o  out  1  pipeline stall request (combinational).
- done_o  out  1  result valid, one-cycle pulse.
- quotient_o  out  WIDTH  to LO.
- remainder_o  out  WIDTH  to HI.

Behaviour:
- Reset: state=IDLE, counter=0. done_o, stall_o, quotient_o and remainder_o are all 0. Reset is asynchronous; asserting it mid-operation discards the divide.
- States: IDLE, BUSY, DONE.
- IDLE, start_i=1, flush_i=0:
  - Capture operands and signed_i.
  - signed: store |dividend| and |divisor|; record q_neg = dividend sign XOR divisor sign, r_neg = dividend sign.
  - divisor==0: go to DONE directly with quotient=all ones, remainder=dividend_i unmodified.
  - Otherwise go to BUSY with counter=0.
- IDLE, any other case: stay.
- BUSY, each cycle: one restoring step.
  - Shift {rem,quo} left by 1; trial = rem[WIDTH:0] − divisor as WIDTH+1 bits.
  - Trial non-negative: rem=trial, quo[0]=1.
  - counter++. After the WIDTH-th step go to DONE.
  - On that transition, register the outputs: quotient = q_neg ? −quo : quo; remainder = r_neg ? −rem : rem, both modulo 2^WIDTH.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. start_i is ignored in DONE (the same instruction is still in EX).
- quotient_o and remainder_o are held from DONE until the next capture. They are not cleared on return to IDLE.
- stall_o = (IDLE & start_i & ~flush_i & divisor_i≠0) | BUSY. It is deasserted in DONE so EX advances that cycle.
- Latency: start seen in cycle T, BUSY for T+1..T+WIDTH, DONE at T+WIDTH+1; stall high T..T+WIDTH. Divide-by-zero: DONE at T+1, no stall.
- flush_i in BUSY: go to IDLE next cycle. No done_o; outputs unchanged; stall_o drops the same cycle (combinational on state & ~flush_i).
- flush_i in IDLE blocks capture. flush_i in DONE: done_o still pulses; the HI/LO write gating is the consumer's responsibility.
- Edge case: 0x80000000 / 0xFFFFFFFF signed gives quotient=0x80000000, remainder=0 with no special-casing (unsigned magnitude 2^31 fits in WIDTH).
- Back-to-back: a new start_i in the cycle after DONE (state IDLE) is accepted normally.

Decomposition:
- Shared defines header (alongside the existing op/funct and ALU control codes):
  - state encodings DIV_IDLE/DIV_BUSY/DIV_DONE;
  - DIV_CYCLES=32;
  - reuse the existing DIV/DIVU funct constants for the decode that drives start_i/signed_i.
- One sub-module: div_step, combinational single restoring iteration.
  - In: rem, quo, divisor. Out: next rem, next quo.
  - Instantiated once in div_unit; unit-testable in isolation.

Test Plan:
- Unsigned: DIVU 100 / 7 at cycle T. Required: stall_o high T..T+32; done_o at T+33 with quotient=14, remainder=2; stall_o low at T+33.
- Signed negative: DIV 0xFFFFFFF9 (−7) / 2. Required: quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also DIV 7 / −2 gives quotient=0xFFFFFFFD, remainder=1.
- Overflow corner: DIV 0x80000000 / 0xFFFFFFFF. Required: quotient=0x80000000, remainder=0, done at T+33.
- Divide by zero: DIVU 0x12345678 / 0. Required: stall_o low throughout; done_o at T+1; quotient=0xFFFFFFFF, remainder=0x12345678.
- Flush: start 100/7, assert flush_i at T+10.
  - Required: stall_o low at T+10; IDLE at T+11; no done_o; outputs still hold the previous result.
  - A new start at T+12 of 50/5 yields quotient=10, remainder=0 at T+45.
- Reset and back-to-back:
  - Assert rst at T+5 of a divide: all outputs 0 immediately (asynchronous), state IDLE.
  - After release, two consecutive DIVUs (9/4 then 10/3, the second started in the cycle after the first DONE) give 2r1 then 3r1, each with a single done_o pulse.
